// File: rtl/fpa_rr_scheduler.sv
// Round-robin front end sharing one FP16 adder between NREQ requesters.
// One transaction in flight; the adder's registered latency is sequenced here.
module fpa_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int ADD_LAT = 1,
  parameter int CNTW    = 16
) (
  input  logic              clk_34,
  input  logic              rst_34,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [16*NREQ-1:0] req_opa,
  input  logic [16*NREQ-1:0] req_opb,
  output logic [NREQ-1:0]   req_ready,
  output logic [15:0]       add_in1,
  output logic [15:0]       add_in2,
  input  logic [15:0]       add_sum,
  input  logic              add_ovf,
  input  logic              add_unf,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_sum,
  output logic              rsp_ovf,
  output logic              rsp_unf,
  output logic              busy,
  output logic [CNTW-1:0]   ovf_cnt,
  output logic [CNTW-1:0]   unf_cnt
);

  localparam int LW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [LW-1:0]   r_lat;
  logic [15:0]     r_in1;
  logic [15:0]     r_in2;
  logic [15:0]     r_sum;
  logic            r_ovf;
  logic            r_unf;
  logic            r_valid;
  logic [CNTW-1:0] r_ovf_cnt;
  logic [CNTW-1:0] r_unf_cnt;
  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_gid;
  logic            w_hs;

  // Descending scan so the closest requester after r_ptr wins last.
  always_comb begin
    int j;
    j     = 0;
    w_gnt = '0;
    w_gid = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = (int'(r_ptr) + k) % NREQ;
      if (req_valid[j]) begin
        w_gnt    = '0;
        w_gnt[j] = 1'b1;
        w_gid    = IDW'(j);
      end
    end
  end

  assign w_hs = (r_state == IDLE) && (|w_gnt);

  always_ff @(posedge clk_34 or posedge rst_34) begin
    if (rst_34) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_hs) w_next = EXEC;
      EXEC: if (r_lat == '0) w_next = CAPT;
      CAPT: w_next = RESP;
      RESP: if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_34 or posedge rst_34) begin
    if (rst_34) begin
      r_ptr     <= IDW'(NREQ - 1);
      r_id      <= '0;
      r_lat     <= '0;
      r_in1     <= '0;
      r_in2     <= '0;
      r_sum     <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_valid   <= 1'b0;
      r_ovf_cnt <= '0;
      r_unf_cnt <= '0;
    end else begin
      if (w_hs) begin
        r_in1 <= req_opa[16*w_gid +: 16];
        r_in2 <= req_opb[16*w_gid +: 16];
        r_id  <= w_gid;
        r_ptr <= w_gid;
        r_lat <= LW'(ADD_LAT - 1);
      end
      if (r_state == EXEC && r_lat != '0)
        r_lat <= r_lat - 1'b1;
      if (r_state == CAPT) begin
        r_sum   <= add_sum;
        r_ovf   <= add_ovf;
        r_unf   <= add_unf;
        r_valid <= 1'b1;
        if (add_ovf && r_ovf_cnt != '1)
          r_ovf_cnt <= r_ovf_cnt + 1'b1;
        if (add_unf && r_unf_cnt != '1)
          r_unf_cnt <= r_unf_cnt + 1'b1;
      end
      if (r_state == RESP && rsp_ready)
        r_valid <= 1'b0;
    end
  end

  // Grant is masked by reset so every output reads 0 while it is held.
  assign req_ready = (r_state == IDLE && !rst_34) ? w_gnt : '0;
  assign add_in1   = r_in1;
  assign add_in2   = r_in2;
  assign rsp_valid = r_valid;
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;
  assign rsp_ovf   = r_ovf;
  assign rsp_unf   = r_unf;
  assign busy      = (r_state != IDLE);
  assign ovf_cnt   = r_ovf_cnt;
  assign unf_cnt   = r_unf_cnt;

endmodule

// File: tb/tb_fpa_rr_scheduler.sv
// Directed bench for fpa_rr_scheduler with a table-driven FP16 adder model.
// A second instance with CNTW=2 runs in lockstep to show counter saturation.
module tb_fpa_rr_scheduler;

  logic        clk_34 = 1'b0;
  logic        rst_34 = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_opa = '0;
  logic [63:0] req_opb = '0;
  logic [3:0]  req_ready;
  logic [15:0] add_in1;
  logic [15:0] add_in2;
  logic [15:0] add_sum = '0;
  logic        add_ovf = 1'b0;
  logic        add_unf = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_sum;
  logic        rsp_ovf;
  logic        rsp_unf;
  logic        busy;
  logic [15:0] ovf_cnt;
  logic [15:0] unf_cnt;

  logic [3:0]  b_req_ready;
  logic [15:0] b_add_in1;
  logic [15:0] b_add_in2;
  logic        b_rsp_valid;
  logic [1:0]  b_rsp_id;
  logic [15:0] b_rsp_sum;
  logic        b_rsp_ovf;
  logic        b_rsp_unf;
  logic        b_busy;
  logic [1:0]  b_ovf_cnt;
  logic [1:0]  b_unf_cnt;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk_34 = ~clk_34;

  fpa_rr_scheduler #(.NREQ(4), .IDW(2), .ADD_LAT(1), .CNTW(16)) u_dut (
    .clk_34(clk_34), .rst_34(rst_34),
    .req_valid(req_valid), .req_opa(req_opa), .req_opb(req_opb),
    .req_ready(req_ready),
    .add_in1(add_in1), .add_in2(add_in2),
    .add_sum(add_sum), .add_ovf(add_ovf), .add_unf(add_unf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_ovf(rsp_ovf), .rsp_unf(rsp_unf),
    .busy(busy), .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt)
  );

  fpa_rr_scheduler #(.NREQ(4), .IDW(2), .ADD_LAT(1), .CNTW(2)) u_dut2 (
    .clk_34(clk_34), .rst_34(rst_34),
    .req_valid(req_valid), .req_opa(req_opa), .req_opb(req_opb),
    .req_ready(b_req_ready),
    .add_in1(b_add_in1), .add_in2(b_add_in2),
    .add_sum(add_sum), .add_ovf(add_ovf), .add_unf(add_unf),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(b_rsp_id),
    .rsp_sum(b_rsp_sum), .rsp_ovf(b_rsp_ovf), .rsp_unf(b_rsp_unf),
    .busy(b_busy), .ovf_cnt(b_ovf_cnt), .unf_cnt(b_unf_cnt)
  );

  // Adder model: {ovf, unf, sum}, one registered stage.
  function automatic logic [17:0] fadd(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3C004000: return {2'b00, 16'h4200};
      32'h3C00BC00: return {2'b01, 16'h0000};
      32'h7BFF7BFF: return {2'b10, 16'h0000};
      default:      return {2'b00, a + b};
    endcase
  endfunction

  always @(posedge clk_34) {add_ovf, add_unf, add_sum} <= fadd(add_in1, add_in2);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_34);
    #1;
  endtask

  task automatic do_reset();
    rst_34 = 1'b1;
    tick();
    tick();
    rst_34 = 1'b0;
  endtask

  // Issue on requester id; returns cycles waited for grant and response latency.
  task automatic do_req(input int id, input logic [15:0] a, input logic [15:0] b,
                        output int gw, output int lat);
    req_opa[16*id +: 16] = a;
    req_opb[16*id +: 16] = b;
    req_valid[id] = 1'b1;
    #1;
    gw = 0;
    while (!req_ready[id] && gw < 40) begin
      tick();
      gw++;
    end
    if (gw >= 40) chk("grant_timeout", 0, 1);
    tick();
    req_valid[id] = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (lat >= 40) chk("rsp_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int gw, lat, ng, n;
    logic [3:0] exp_g [5];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;

    tick();
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_add_in1", add_in1, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    do_reset();

    // 1. basic add and latency
    do_req(0, 16'h3C00, 16'h4000, gw, lat);
    chk("t1_gw", gw, 0);
    chk("t1_lat", lat, 2);
    chk("t1_sum", rsp_sum, 16'h4200);
    chk("t1_id", rsp_id, 0);
    chk("t1_flags", {rsp_ovf, rsp_unf}, 0);
    wait_idle();

    // 3. flags and counters
    do_req(1, 16'h3C00, 16'hBC00, gw, lat);
    chk("t3_unf_sum", rsp_sum, 16'h0000);
    chk("t3_unf", rsp_unf, 1);
    chk("t3_unf_cnt", unf_cnt, 1);
    chk("t3_unf_id", rsp_id, 1);
    wait_idle();
    do_req(2, 16'h7BFF, 16'h7BFF, gw, lat);
    chk("t3_ovf", rsp_ovf, 1);
    chk("t3_ovf_sum", rsp_sum, 16'h0000);
    chk("t3_ovf_cnt", ovf_cnt, 1);
    wait_idle();

    // 2. round-robin fairness
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_opa[16*i +: 16] = 16'(i + 1);
      req_opb[16*i +: 16] = 16'h0100;
    end
    req_valid = 4'b1111;
    ng = 0;
    n = 0;
    #1;
    while (ng < 5 && n < 100) begin
      if (|req_ready) begin
        chk($sformatf("t2_grant%0d", ng), req_ready, exp_g[ng]);
        ng++;
      end
      if (ng < 5) begin
        tick();
        n++;
      end
    end
    if (ng < 5) chk("t2_grant_timeout", ng, 5);
    tick();
    req_valid = 4'b0100;
    n = 0;
    while (!(|req_ready) && n < 40) begin
      tick();
      n++;
    end
    chk("t2_grant_req2", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk("t2_req2_id", rsp_id, 2);
    chk("t2_req2_sum", rsp_sum, 16'h0103);
    wait_idle();

    // 4. backpressure
    rsp_ready = 1'b0;
    do_req(3, 16'h1111, 16'h2222, gw, lat);
    req_opa[15:0] = 16'h0005;
    req_opb[15:0] = 16'h0006;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_valid", rsp_valid, 1);
      chk("t4_sum", rsp_sum, 16'h3333);
      chk("t4_id", rsp_id, 3);
      chk("t4_ready", req_ready, 0);
      chk("t4_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    tick();
    chk("t4_idle", busy, 0);
    chk("t4_next_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk("t4_next_sum", rsp_sum, 16'h000B);
    wait_idle();

    // 5a. reset during EXEC
    req_opa[31:16] = 16'h1234;
    req_opb[31:16] = 16'h0001;
    req_valid[1] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[1] && n < 40) begin
      tick();
      n++;
    end
    tick();
    chk("t5_in_exec", busy, 1);
    rst_34 = 1'b1;
    #1;
    chk("t5e_busy", busy, 0);
    chk("t5e_add_in1", add_in1, 0);
    chk("t5e_req_ready", req_ready, 0);
    chk("t5e_rsp_valid", rsp_valid, 0);
    tick();
    rst_34 = 1'b0;
    req_valid = 4'b0010;
    do_req(0, 16'h3C00, 16'h4000, gw, lat);
    req_valid = '0;
    chk("t5e_first_gw", gw, 0);
    chk("t5e_sum", rsp_sum, 16'h4200);
    chk("t5e_id", rsp_id, 0);
    wait_idle();

    // 5b. reset during RESP
    rsp_ready = 1'b0;
    do_req(2, 16'h3C00, 16'hBC00, gw, lat);
    chk("t5r_in_resp", rsp_valid, 1);
    rst_34 = 1'b1;
    #1;
    chk("t5r_rsp_valid", rsp_valid, 0);
    chk("t5r_unf", rsp_unf, 0);
    chk("t5r_unf_cnt", unf_cnt, 0);
    chk("t5r_busy", busy, 0);
    tick();
    rst_34 = 1'b0;
    rsp_ready = 1'b1;
    do_req(0, 16'h3C00, 16'h4000, gw, lat);
    chk("t5r_first_gw", gw, 0);
    chk("t5r_sum", rsp_sum, 16'h4200);
    wait_idle();

    // 6. counter saturation
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_req(i % 4, 16'h7BFF, 16'h7BFF, gw, lat);
      wait_idle();
    end
    chk("t6_ovf_cnt16", ovf_cnt, 5);
    chk("t6_ovf_cnt2_sat", b_ovf_cnt, 3);
    chk("t6_unf_cnt2", b_unf_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
